// File: rtl/rec_pkg.sv
// rec_pkg: shared definitions for the rec_sequencer slice.
// Holds the FSM state enum, the register/operand/result select encodings
// driven onto the datapath decoder, the datapath width, and a helper that
// sizes the iteration counter.
package rec_pkg;

  localparam int unsigned DATA_W = 32;

  typedef logic [1:0] sel_t;

  typedef enum logic [3:0] {
    StIdle,
    StLdN,
    StLdA,
    StLdB,
    StCheck,
    StMul,
    StAdd,
    StInc,
    StFin,
    StAbort
  } state_e;

  // Destination register (wsel)
  localparam sel_t WSEL_A = 2'd0;
  localparam sel_t WSEL_B = 2'd1;
  localparam sel_t WSEL_N = 2'd2;

  // Operand mux (osel)
  localparam sel_t OSEL_A    = 2'd0;
  localparam sel_t OSEL_B    = 2'd1;
  localparam sel_t OSEL_N    = 2'd2;
  localparam sel_t OSEL_ZERO = 2'd3;

  // Result mux (alusel)
  localparam sel_t ALU_INC   = 2'd0;
  localparam sel_t ALU_SUM   = 2'd1;
  localparam sel_t ALU_MUL14 = 2'd2;
  localparam sel_t ALU_DIN   = 2'd3;

  // Counter must be able to hold MAX_ITER itself.
  function automatic int unsigned cnt_width(int unsigned max_iter);
    return $clog2(max_iter + 1);
  endfunction

endpackage

// File: rtl/rec_sequencer_if.sv
// rec_sequencer_if: control bundle between the sequencer and its datapath.
//   start, din_valid, eq : requests/status into the sequencer
//   wen, wsel, osel, alusel : register-write decode out of the sequencer
//   busy, done, err : run status out of the sequencer
// master = datapath/environment side, slave = sequencer side.
interface rec_sequencer_if;
  import rec_pkg::*;

  logic start;
  logic din_valid;
  logic eq;
  logic wen;
  sel_t wsel;
  sel_t osel;
  sel_t alusel;
  logic busy;
  logic done;
  logic err;

  modport master (
    output start, din_valid, eq,
    input  wen, wsel, osel, alusel, busy, done, err
  );

  modport slave (
    input  start, din_valid, eq,
    output wen, wsel, osel, alusel, busy, done, err
  );

endinterface

// File: rtl/rec_iter_cnt.sv
// rec_iter_cnt: iteration counter for rec_sequencer.
//   clk, res    : clock, synchronous active-high reset
//   clr_i       : clear to zero (priority over inc_i)
//   inc_i       : count one iteration; saturates at MAX_ITER
//   at_limit_o  : counter equals MAX_ITER
module rec_iter_cnt import rec_pkg::*; #(
  parameter int unsigned MAX_ITER = 1024
) (
  input  logic clk,
  input  logic res,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);

  localparam int unsigned CntW = cnt_width(MAX_ITER);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign at_limit_o = (cnt_q == CntW'(MAX_ITER));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_limit_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rec_sequencer.sv
// rec_sequencer: control FSM for the recurrence A(k+1) = 14*A(k) + k.
// Loads N, A, B from din, then iterates CHECK/MUL/ADD/INC until B == N
// (done pulse) or MAX_ITER iterations elapse (err pulse).
//   clk, res : clock, synchronous active-high reset
//   bus      : rec_sequencer_if.slave (start, din_valid, eq in;
//              wen, wsel, osel, alusel, busy, done, err out)
// All outputs are Moore decodes of state; only wen in load states also
// follows din_valid.
module rec_sequencer import rec_pkg::*; #(
  parameter int unsigned MAX_ITER = 1024
) (
  input  logic             clk,
  input  logic             res,
  rec_sequencer_if.slave   bus
);

  state_e state_q, state_d;
  logic   wen, busy, done, err;
  sel_t   wsel, osel, alusel;
  logic   cnt_clr, cnt_inc, at_limit;

  rec_iter_cnt #(
    .MAX_ITER (MAX_ITER)
  ) u_iter_cnt (
    .clk        (clk),
    .res        (res),
    .clr_i      (cnt_clr),
    .inc_i      (cnt_inc),
    .at_limit_o (at_limit)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wen     = 1'b0;
    wsel    = WSEL_A;
    osel    = OSEL_A;
    alusel  = ALU_INC;
    done    = 1'b0;
    err     = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    busy    = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StLdN;
      end
      StLdN: begin
        wen    = bus.din_valid;
        wsel   = WSEL_N;
        alusel = ALU_DIN;
        if (bus.din_valid) state_d = StLdA;
      end
      StLdA: begin
        wen    = bus.din_valid;
        wsel   = WSEL_A;
        alusel = ALU_DIN;
        if (bus.din_valid) state_d = StLdB;
      end
      StLdB: begin
        wen    = bus.din_valid;
        wsel   = WSEL_B;
        alusel = ALU_DIN;
        if (bus.din_valid) begin
          cnt_clr = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (bus.eq) begin
          state_d = StFin;
        end else if (at_limit) begin
          state_d = StAbort;
        end else begin
          state_d = StMul;
        end
      end
      StMul: begin
        wen     = 1'b1;
        wsel    = WSEL_A;
        osel    = OSEL_A;
        alusel  = ALU_MUL14;
        state_d = StAdd;
      end
      StAdd: begin
        wen     = 1'b1;
        wsel    = WSEL_A;
        osel    = OSEL_A;
        alusel  = ALU_SUM;
        state_d = StInc;
      end
      StInc: begin
        wen     = 1'b1;
        wsel    = WSEL_B;
        osel    = OSEL_B;
        alusel  = ALU_INC;
        cnt_inc = 1'b1;
        state_d = StCheck;
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      StAbort: begin
        err     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.wen    = wen;
  assign bus.wsel   = wsel;
  assign bus.osel   = osel;
  assign bus.alusel = alusel;
  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.err    = err;

endmodule

// File: tb/tb_rec_sequencer.sv
// tb_rec_sequencer: table-driven bench for rec_sequencer with a behavioural
// A/B/N datapath. Uses MAX_ITER=4 so the timeout path is reachable quickly.
module tb_rec_sequencer;
  import rec_pkg::*;

  localparam int unsigned MaxIter = 4;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] ra = '0, rb = '0, rn = '0;

  int n_checks = 0;
  int n_pass   = 0;

  rec_sequencer_if bus ();

  rec_sequencer #(
    .MAX_ITER (MaxIter)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Datapath model: operand mux, result mux, three registers, comparator.
  function automatic logic [DATA_W-1:0] alu(input sel_t o, input sel_t f);
    logic [DATA_W-1:0] op;
    case (o)
      OSEL_A:  op = ra;
      OSEL_B:  op = rb;
      OSEL_N:  op = rn;
      default: op = '0;
    endcase
    case (f)
      ALU_INC:   return op + 32'd1;
      ALU_SUM:   return op + rb;
      ALU_MUL14: return op * 32'd14;
      default:   return din;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.wen) begin
      case (bus.wsel)
        WSEL_A:  ra <= alu(bus.osel, bus.alusel);
        WSEL_B:  rb <= alu(bus.osel, bus.alusel);
        WSEL_N:  rn <= alu(bus.osel, bus.alusel);
        default: ;
      endcase
    end
  end

  assign bus.eq = (rb == rn);

  typedef struct {
    string       name;
    logic [31:0] n, a, b;
    int          stall;     // din_valid low cycles while in LD_A
    int          xstart;    // cycle index of a stray start pulse, -1 none
    logic        exp_done;  // 1: done expected, 0: err expected
    logic [31:0] exp_a;
    int          exp_lat;   // cycles from LD_N write to done/err
    int          exp_iter;  // MUL/ADD/INC writes
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] outs_vec();
    return {22'd0, bus.wen, bus.wsel, bus.osel, bus.alusel, bus.busy, bus.done, bus.err};
  endfunction

  task automatic run_seq(input vec_t v, input int rst_at_add,
                         output int done_cnt, output int err_cnt, output int ld_wr,
                         output int iter_wr, output int lat, output logic [5:0] ld_order,
                         output int stall_wr, output logic busy_after, output logic timed_out);
    logic [31:0] vals [3];
    int   idx, t0, stall_left, add_cnt;
    logic fin, stalling;
    vals[0] = v.n; vals[1] = v.a; vals[2] = v.b;
    done_cnt = 0; err_cnt = 0; ld_wr = 0; iter_wr = 0; lat = -1; ld_order = '0;
    stall_wr = 0; busy_after = 1'b1; timed_out = 1'b1;
    idx = 0; t0 = 0; stall_left = v.stall; add_cnt = 0; fin = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.din_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      bus.start = (cyc == v.xstart);
      din = vals[(idx > 2) ? 2 : idx];
      stalling = 1'b0;
      if (idx == 1 && stall_left > 0) begin
        bus.din_valid = 1'b0;
        stalling = 1'b1;
        stall_left--;
      end else begin
        bus.din_valid = (idx < 3);
      end
      #1;
      if (stalling && bus.wen) stall_wr++;
      if (bus.wen && bus.alusel == ALU_DIN) begin
        if (ld_wr == 0) t0 = cyc;
        if (ld_wr < 3) ld_order = {ld_order[3:0], bus.wsel};
        ld_wr++;
        idx++;
      end else if (bus.wen) begin
        iter_wr++;
        if (bus.alusel == ALU_SUM) add_cnt++;
      end
      if (rst_at_add != 0 && add_cnt == rst_at_add) begin
        res = 1'b1;
        timed_out = 1'b0;
        fin = 1'b1;
      end else if (bus.done || bus.err) begin
        done_cnt += int'(bus.done);
        err_cnt  += int'(bus.err);
        lat = cyc - t0;
        @(negedge clk);
        #1;
        busy_after = bus.busy;
        timed_out = 1'b0;
        fin = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    bus.din_valid = 1'b0;
  endtask

  initial begin
    int   done_cnt, err_cnt, ld_wr, iter_wr, lat, stall_wr;
    logic [5:0] ld_order;
    logic busy_after, timed_out;
    vec_t v;

    vecs[0] = '{"nominal",  32'd3, 32'd1, 32'd0, 0, -1, 1'b1, 32'd2760, 16, 9};
    vecs[1] = '{"equal",    32'd5, 32'd7, 32'd5, 0, -1, 1'b1, 32'd7,     4, 0};
    vecs[2] = '{"timeout",  32'd2, 32'd0, 32'd3, 0, -1, 1'b0, 32'd0,    20, 12};
    vecs[3] = '{"one_iter", 32'd1, 32'd2, 32'd0, 0, -1, 1'b1, 32'd28,    8, 3};
    vecs[4] = '{"wrap",     32'd1, 32'h2000_0000, 32'd0, 0, -1, 1'b1, 32'hC000_0000, 8, 3};
    vecs[5] = '{"stall",    32'd3, 32'd1, 32'd0, 4, -1, 1'b1, 32'd2760, 20, 9};
    vecs[6] = '{"xstart",   32'd3, 32'd1, 32'd0, 0,  6, 1'b1, 32'd2760, 16, 9};
    vecs[7] = '{"two_iter", 32'd2, 32'd5, 32'd0, 0, -1, 1'b1, 32'd981,  12, 6};

    bus.start = 1'b0;
    bus.din_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outs", outs_vec(), 32'd0);
    res = 1'b0;

    foreach (vecs[i]) begin
      v = vecs[i];
      run_seq(v, 0, done_cnt, err_cnt, ld_wr, iter_wr, lat, ld_order, stall_wr,
              busy_after, timed_out);
      check({v.name, "_timeout"}, 32'(timed_out), 32'd0);
      check({v.name, "_done"}, done_cnt, 32'(v.exp_done));
      check({v.name, "_err"}, err_cnt, 32'(!v.exp_done));
      check({v.name, "_loads"}, ld_wr, 32'd3);
      check({v.name, "_ld_order"}, 32'(ld_order), {26'd0, WSEL_N, WSEL_A, WSEL_B});
      check({v.name, "_iter_writes"}, iter_wr, v.exp_iter);
      check({v.name, "_latency"}, lat, v.exp_lat);
      check({v.name, "_busy_after"}, 32'(busy_after), 32'd0);
      if (v.exp_done) check({v.name, "_result_a"}, ra, v.exp_a);
      if (v.stall > 0) check({v.name, "_stall_wen"}, stall_wr, 32'd0);
    end

    // Reset during the second ADD of a nominal run, then a fresh run.
    run_seq(vecs[0], 2, done_cnt, err_cnt, ld_wr, iter_wr, lat, ld_order, stall_wr,
            busy_after, timed_out);
    check("midrun_reached_add2", 32'(timed_out), 32'd0);
    check("midrun_no_done", done_cnt + err_cnt, 32'd0);
    @(negedge clk);
    #1;
    check("midrun_reset_outs", outs_vec(), 32'd0);
    res = 1'b0;
    @(negedge clk);
    #1;
    check("midrun_idle_hold", outs_vec(), 32'd0);
    v = vecs[3];
    run_seq(v, 0, done_cnt, err_cnt, ld_wr, iter_wr, lat, ld_order, stall_wr,
            busy_after, timed_out);
    check("after_reset_done", done_cnt, 32'd1);
    check("after_reset_result_a", ra, 32'd28);
    check("after_reset_latency", lat, 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
